// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch front end of the 5-stage MIPS pipeline. It owns the fetch
// PC and drives a req/ack instruction-memory port with at most one
// transaction outstanding. Fetched words are buffered in a 2-entry FIFO of
// {addr+4, word}. The head entry is presented to the IF/ID register. The head
// is held while hazard_detected is high, and a taken branch flushes the FIFO.
//
// Ports:
//   clk              single clock, rising edge
//   rst              synchronous active-high reset
//   hazard_detected  freeze: head instruction is not consumed
//   branch_taken     redirect request and IF/ID flush
//   branch_addr      redirect target (32)
//   imem_req         fetch request to instruction memory
//   imem_addr        fetch address (32), stable while imem_req is high
//   imem_ack         memory completion, imem_rdata valid in the same cycle
//   imem_rdata       fetched word (32)
//   PC               head instruction address + 4, 0 when empty (32)
//   instruction      head instruction, NOP (0) when empty (32)
//   fetch_valid      FIFO non-empty
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard_detected,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic        fetch_valid
);

    // FETCH: normal operation. DRAIN: a redirect left a request in flight,
    // and it must complete on its old address before fetching resumes.
    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_inc;
    logic [31:0] drain_addr;

    // Entry 0 is always the head, and entry 1 is only meaningful at count 2.
    logic [31:0] head_pc;
    logic [31:0] head_word;
    logic [31:0] tail_pc;
    logic [31:0] tail_word;
    logic [1:0]  count;

    logic        accept;
    logic        consume;
    logic        pending_no_ack;

    assign fetch_pc_inc = fetch_pc + 32'd4;

    // A word is taken only in FETCH. A redirect on the same edge discards it.
    assign accept  = (state == FETCH) && imem_req && imem_ack && !branch_taken;
    assign consume = fetch_valid && !hazard_detected && !branch_taken;

    // True when a request from FETCH is still waiting at this edge. A redirect
    // seen here must keep that address on the bus until the ack arrives.
    assign pending_no_ack = (state == FETCH) && imem_req && !imem_ack;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. DRAIN lasts until the in-flight ack. A further redirect
    // while draining only retargets fetch_pc, so it does not change state here.
    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (branch_taken && pending_no_ack) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // Output logic. The request comes from registered state only. The rst
    // term keeps the port quiet during the reset cycle, even if the unit was
    // mid-drain.
    always_comb begin
        imem_req    = !rst && ((state == DRAIN) || (count != 2'd2));
        imem_addr   = (state == DRAIN) ? drain_addr : fetch_pc;
        fetch_valid = (count != 2'd0);
        PC          = fetch_valid ? head_pc : 32'h0000_0000;
        instruction = fetch_valid ? head_word : 32'h0000_0000;
    end

    // Fetch PC, drain address and FIFO. Priority: reset, then redirect, then
    // the normal push/pop. A simultaneous push and pop can only occur at
    // count 1, because a full FIFO never requests and an empty one cannot pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            drain_addr <= RESET_PC;
            count      <= 2'd0;
            head_pc    <= 32'h0000_0000;
            head_word  <= 32'h0000_0000;
            tail_pc    <= 32'h0000_0000;
            tail_word  <= 32'h0000_0000;
        end else if (branch_taken) begin
            count    <= 2'd0;
            fetch_pc <= branch_addr;
            if (pending_no_ack) begin
                drain_addr <= fetch_pc;
            end
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc_inc;
            end
            case ({accept, consume})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_pc   <= fetch_pc_inc;
                        head_word <= imem_rdata;
                    end else begin
                        tail_pc   <= fetch_pc_inc;
                        tail_word <= imem_rdata;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_pc   <= tail_pc;
                    head_word <= tail_word;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    head_pc   <= fetch_pc_inc;
                    head_word <= imem_rdata;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
